// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - walks the shuffled-address table once per epoch and hands
// each fetched linear address to the SOM training core over valid/ready.
module sample_sequencer #(
    parameter int NUM_SAMPLES = 8192,
    parameter int NUM_EPOCHS  = 16,
    parameter int EPOCH_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_read_en,
    output logic [12:0]        o_amem_addr,
    input  logic [17:0]        i_ram_a,
    output logic               o_sample_valid,
    output logic [17:0]        o_sample_addr,
    input  logic               i_sample_ready,
    output logic [12:0]        o_sample_idx,
    output logic [EPOCH_W-1:0] o_epoch,
    output logic               o_epoch_done,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_EPOCH_END,
        S_DONE
    } state_t;

    localparam logic [12:0]        LAST_IDX   = 13'(NUM_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(NUM_EPOCHS - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE  = EPOCH_W'(1);

    state_t               r_state;
    state_t               w_next;
    logic [12:0]          r_idx;
    logic [EPOCH_W-1:0]   r_epoch;
    logic [17:0]          r_sample_addr;
    logic                 r_sample_valid;
    logic                 w_handshake;
    logic                 w_last_idx;
    logic                 w_last_epoch;

    assign w_handshake  = r_sample_valid & i_sample_ready;
    assign w_last_idx   = (r_idx == LAST_IDX);
    assign w_last_epoch = (r_epoch == LAST_EPOCH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_next = S_FETCH;
            end
            S_FETCH: w_next = S_HOLD;
            S_HOLD: begin
                if (w_handshake) w_next = w_last_idx ? S_EPOCH_END : S_FETCH;
            end
            S_EPOCH_END: w_next = w_last_epoch ? S_DONE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // The address memory answers combinationally, so the sample is captured on the FETCH edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx          <= '0;
            r_epoch        <= '0;
            r_sample_addr  <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_epoch <= '0;
                    end
                end
                S_FETCH: begin
                    r_sample_addr  <= i_ram_a;
                    r_sample_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_sample_valid <= 1'b0;
                        if (!w_last_idx) r_idx <= r_idx + 13'd1;
                    end
                end
                S_EPOCH_END: begin
                    if (!w_last_epoch) begin
                        r_epoch <= r_epoch + EPOCH_ONE;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_sample_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_en      = (r_state == S_FETCH);
    assign o_amem_addr    = r_idx;
    assign o_sample_idx   = r_idx;
    assign o_sample_valid = r_sample_valid;
    assign o_sample_addr  = r_sample_addr;
    assign o_epoch        = r_epoch;
    assign o_epoch_done   = (r_state == S_EPOCH_END);
    assign o_busy         = (r_state == S_FETCH) || (r_state == S_HOLD) || (r_state == S_EPOCH_END);
    assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - directed bench: small 4x2 run plus an 8192x1 boundary run.
module tb_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, ready_a, start_b, ready_b;

    logic        read_en_a, valid_a, edone_a, busy_a, done_a;
    logic [12:0] amem_a, sidx_a;
    logic [17:0] ram_a, saddr_a;
    logic [7:0]  epoch_a;
    logic [4:0]  flags_a;

    logic        read_en_b, valid_b, edone_b, busy_b, done_b;
    logic [12:0] amem_b, sidx_b;
    logic [17:0] ram_b, saddr_b;
    logic [7:0]  epoch_b;
    logic [4:0]  flags_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Address memory models: a maps i -> row i+1, col 3; b maps i -> i+7.
    assign ram_a   = 18'((32'(amem_a) + 1) * 512 + 3);
    assign ram_b   = 18'(32'(amem_b) + 7);
    assign flags_a = {read_en_a, valid_a, edone_a, busy_a, done_a};
    assign flags_b = {read_en_b, valid_b, edone_b, busy_b, done_b};

    sample_sequencer #(.NUM_SAMPLES(4), .NUM_EPOCHS(2), .EPOCH_W(8)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a),
        .o_read_en(read_en_a), .o_amem_addr(amem_a), .i_ram_a(ram_a),
        .o_sample_valid(valid_a), .o_sample_addr(saddr_a), .i_sample_ready(ready_a),
        .o_sample_idx(sidx_a), .o_epoch(epoch_a), .o_epoch_done(edone_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    sample_sequencer #(.NUM_SAMPLES(8192), .NUM_EPOCHS(1), .EPOCH_W(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b),
        .o_read_en(read_en_b), .o_amem_addr(amem_b), .i_ram_a(ram_b),
        .o_sample_valid(valid_b), .o_sample_addr(saddr_b), .i_sample_ready(ready_b),
        .o_sample_idx(sidx_b), .o_epoch(epoch_b), .o_epoch_done(edone_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // flags order: {read_en, sample_valid, epoch_done, busy, done}
    logic [1:19] t_rd, t_vl, t_ed, t_bz, t_dn;
    int          t_idx [19];

    int          c_ed, c_dn, n_ed;
    logic [12:0] max_amem, idx_at_ed;
    logic [17:0] sa_at_ed;

    initial begin
        t_rd  = 19'b1010101001010101000;
        t_vl  = 19'b0101010100101010100;
        t_ed  = 19'b0000000010000000010;
        t_bz  = 19'b1111111111111111110;
        t_dn  = 19'b0000000000000000001;
        t_idx = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};

        // Reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_a = 1'($urandom_range(0, 1));
            ready_a = 1'($urandom_range(0, 1));
            start_b = 1'($urandom_range(0, 1));
            ready_b = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("rst_flags_a", 32'(flags_a), 0);
        check("rst_amem_a", 32'(amem_a), 0);
        check("rst_saddr_a", 32'(saddr_a), 0);
        check("rst_sidx_a", 32'(sidx_a), 0);
        check("rst_epoch_a", 32'(epoch_a), 0);
        check("rst_flags_b", 32'(flags_b), 0);
        check("rst_saddr_b", 32'(saddr_b), 0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        cyc(); cyc(); cyc();
        check("post_rst_flags_a", 32'(flags_a), 0);
        check("post_rst_amem_a", 32'(amem_a), 0);
        check("post_rst_flags_b", 32'(flags_b), 0);

        // Nominal run, cycle 1 is the first cycle after the edge that samples start
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            check($sformatf("nom_flags_c%0d", c), 32'(flags_a),
                  32'({t_rd[c], t_vl[c], t_ed[c], t_bz[c], t_dn[c]}));
            check($sformatf("nom_amem_c%0d", c), 32'(amem_a), 32'(t_idx[c-1]));
            check($sformatf("nom_sidx_c%0d", c), 32'(sidx_a), 32'(t_idx[c-1]));
            check($sformatf("nom_epoch_c%0d", c), 32'(epoch_a), (c >= 10) ? 32'd1 : 32'd0);
            if (t_vl[c])
                check($sformatf("nom_saddr_c%0d", c), 32'(saddr_a), 32'(515 + 512 * t_idx[c-1]));
            if (c < 19) cyc();
        end

        // Restart from DONE, then backpressure in HOLD at idx 2
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        check("restart_flags", 32'(flags_a), 32'(5'b10010));
        check("restart_epoch", 32'(epoch_a), 0);
        check("restart_idx", 32'(amem_a), 0);
        cyc(); cyc(); cyc(); cyc();
        check("bp_fetch2_flags", 32'(flags_a), 32'(5'b10010));
        check("bp_fetch2_amem", 32'(amem_a), 2);
        ready_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("bp_hold_flags_%0d", k), 32'(flags_a), 32'(5'b01010));
            check($sformatf("bp_hold_amem_%0d", k), 32'(amem_a), 2);
            check($sformatf("bp_hold_saddr_%0d", k), 32'(saddr_a), 1539);
            start_a = (k == 1);
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        cyc();
        check("bp_fetch3_flags", 32'(flags_a), 32'(5'b10010));
        check("bp_fetch3_amem", 32'(amem_a), 3);
        cyc();
        check("bp_hold3_saddr", 32'(saddr_a), 2051);
        cyc();
        check("bp_eend_flags", 32'(flags_a), 32'(5'b00110));
        cyc();
        check("e1_fetch0_epoch", 32'(epoch_a), 1);
        check("e1_fetch0_amem", 32'(amem_a), 0);
        cyc(); cyc();
        ready_a = 1'b0;
        cyc();
        check("e1_hold1_flags", 32'(flags_a), 32'(5'b01010));
        check("e1_hold1_amem", 32'(amem_a), 1);
        check("e1_hold1_saddr", 32'(saddr_a), 1027);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        check("arst_flags", 32'(flags_a), 0);
        check("arst_amem", 32'(amem_a), 0);
        check("arst_saddr", 32'(saddr_a), 0);
        check("arst_epoch", 32'(epoch_a), 0);
        @(negedge clk);
        rst = 1'b0;
        ready_a = 1'b1;
        cyc();
        check("arst_idle_flags", 32'(flags_a), 0);
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        check("arst_restart_flags", 32'(flags_a), 32'(5'b10010));
        check("arst_restart_epoch", 32'(epoch_a), 0);
        check("arst_restart_amem", 32'(amem_a), 0);
        cyc();
        check("arst_restart_saddr", 32'(saddr_a), 515);

        // Boundary: 8192 samples, one epoch
        c_ed = -1; c_dn = -1; n_ed = 0; max_amem = '0; idx_at_ed = '0; sa_at_ed = '0;
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        for (int c = 1; c <= 17000 && c_dn < 0; c++) begin
            if (read_en_b && amem_b > max_amem) max_amem = amem_b;
            if (edone_b) begin
                n_ed++;
                c_ed = c;
                sa_at_ed = saddr_b;
                idx_at_ed = amem_b;
            end
            if (done_b) c_dn = c;
            else cyc();
        end
        check("bnd_done_cycle", 32'(c_dn), 16386);
        check("bnd_edone_cycle", 32'(c_ed), 16385);
        check("bnd_edone_count", 32'(n_ed), 1);
        check("bnd_max_amem", 32'(max_amem), 8191);
        check("bnd_idx_at_edone", 32'(idx_at_ed), 8191);
        check("bnd_saddr_at_edone", 32'(sa_at_ed), 8198);
        check("bnd_epoch_final", 32'(epoch_b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
